// File: rtl/idex_stage.sv
// idex_stage: ID/EX pipeline register for the 16-bit CPU.
//
// Captures the decoded operands and control from ID and presents them to EX
// and to the forwarding unit as idex_*. EX/MEM forwarding does not cover loads,
// so this block also detects load-use hazards against the instructions now in
// ID/EX and EX/MEM. On a hazard it freezes PC and IF/ID, inserts a bubble and
// counts the bubble in a saturating counter.
//
// Ports
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   id_*                  : decoded instruction presented by the ID stage
//   exmem_reg_write,
//   exmem_mem_to_reg,
//   exmem_rd              : control of the instruction in EX/MEM
//   hold                  : downstream freeze, register keeps its value
//   ex_flush              : redirect resolved in EX, load a bubble
//   cnt_clr               : synchronous clear of stall_cnt
//   idex_*                : registered ID/EX fields (all zero for a bubble)
//   stall_if_id           : combinational freeze request for PC and IF/ID
//   stall_cnt             : saturating count of load-use bubbles

module idex_stage (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        id_valid,
  input  logic [3:0]  id_rs1,
  input  logic [3:0]  id_rs2,
  input  logic [3:0]  id_rd,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        id_reg_write,
  input  logic        id_mem_to_reg,
  input  logic        id_mem_write,
  input  logic [3:0]  id_alu_op,
  input  logic [15:0] id_rs1_data,
  input  logic [15:0] id_rs2_data,
  input  logic [15:0] id_imm,
  input  logic [15:0] id_pc,

  input  logic        exmem_reg_write,
  input  logic        exmem_mem_to_reg,
  input  logic [3:0]  exmem_rd,

  input  logic        hold,
  input  logic        ex_flush,
  input  logic        cnt_clr,

  output logic        idex_valid,
  output logic        idex_reg_write,
  output logic        idex_mem_to_reg,
  output logic        idex_mem_write,
  output logic [3:0]  idex_rs1,
  output logic [3:0]  idex_rs2,
  output logic [3:0]  idex_rd,
  output logic [3:0]  idex_alu_op,
  output logic [15:0] idex_rs1_data,
  output logic [15:0] idex_rs2_data,
  output logic [15:0] idex_imm,
  output logic [15:0] idex_pc,

  output logic        stall_if_id,
  output logic [15:0] stall_cnt
);

  localparam int unsigned REG_W  = 4;
  localparam int unsigned ALU_W  = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 16;

  // Full ID/EX payload; an all-zero value is a bubble.
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [ALU_W-1:0]  alu_op;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
  } idex_t;

  idex_t            idex_q;
  idex_t            idex_d;
  idex_t            id_fields;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic ex_is_load;
  logic mem_is_load;
  logic ex_match;
  logic mem_match;
  logic lu;
  logic lu_bubble;

  // Gather the ID fields into one payload.
  always_comb begin
    id_fields            = '0;
    id_fields.valid      = 1'b1;
    id_fields.reg_write  = id_reg_write;
    id_fields.mem_to_reg = id_mem_to_reg;
    id_fields.mem_write  = id_mem_write;
    id_fields.rs1        = id_rs1;
    id_fields.rs2        = id_rs2;
    id_fields.rd         = id_rd;
    id_fields.alu_op     = id_alu_op;
    id_fields.rs1_data   = id_rs1_data;
    id_fields.rs2_data   = id_rs2_data;
    id_fields.imm        = id_imm;
    id_fields.pc         = id_pc;
  end

  // Load-use detection against the loads now in ID/EX and EX/MEM; r0 never hazards.
  always_comb begin
    ex_is_load  = idex_q.valid & idex_q.reg_write & idex_q.mem_to_reg &
                  (idex_q.rd != REG_W'(0));
    mem_is_load = exmem_reg_write & exmem_mem_to_reg & (exmem_rd != REG_W'(0));

    ex_match    = ex_is_load &
                  ((id_uses_rs1 & (id_rs1 == idex_q.rd)) |
                   (id_uses_rs2 & (id_rs2 == idex_q.rd)));
    mem_match   = mem_is_load &
                  ((id_uses_rs1 & (id_rs1 == exmem_rd)) |
                   (id_uses_rs2 & (id_rs2 == exmem_rd)));

    lu          = id_valid & (ex_match | mem_match);
    // Only a bubble actually caused by the hazard is counted.
    lu_bubble   = ~hold & ~ex_flush & lu;
  end

  // A flush replaces ID with a wrong-path instruction, so it must not be frozen.
  assign stall_if_id = hold | (lu & ~ex_flush);

  // Next payload: hold > flush > load-use > capture.
  always_comb begin
    idex_d = idex_q;
    if (!hold) begin
      if (ex_flush || lu || !id_valid) begin
        idex_d = '0;
      end else begin
        idex_d = id_fields;
      end
    end
  end

  // Saturating bubble counter; clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (lu_bubble && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Pipeline register and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q <= '0;
      cnt_q  <= '0;
    end else begin
      idex_q <= idex_d;
      cnt_q  <= cnt_d;
    end
  end

  assign idex_valid      = idex_q.valid;
  assign idex_reg_write  = idex_q.reg_write;
  assign idex_mem_to_reg = idex_q.mem_to_reg;
  assign idex_mem_write  = idex_q.mem_write;
  assign idex_rs1        = idex_q.rs1;
  assign idex_rs2        = idex_q.rs2;
  assign idex_rd         = idex_q.rd;
  assign idex_alu_op     = idex_q.alu_op;
  assign idex_rs1_data   = idex_q.rs1_data;
  assign idex_rs2_data   = idex_q.rs2_data;
  assign idex_imm        = idex_q.imm;
  assign idex_pc         = idex_q.pc;
  assign stall_cnt       = cnt_q;

endmodule

// File: tb/tb_idex_stage.sv
// Bench for idex_stage: a spec-level model predicts the stall output and the
// next ID/EX contents each cycle; predictions go into a scoreboard queue and
// are compared after the edge. Scenario tasks add their own targeted checks.

module tb_idex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [3:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic        id_reg_write, id_mem_to_reg, id_mem_write;
  logic [3:0]  id_alu_op;
  logic [15:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic        exmem_reg_write, exmem_mem_to_reg;
  logic [3:0]  exmem_rd;
  logic        hold, ex_flush, cnt_clr;
  logic        idex_valid, idex_reg_write, idex_mem_to_reg, idex_mem_write;
  logic [3:0]  idex_rs1, idex_rs2, idex_rd, idex_alu_op;
  logic [15:0] idex_rs1_data, idex_rs2_data, idex_imm, idex_pc;
  logic        stall_if_id;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  idex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .id_mem_write(id_mem_write), .id_alu_op(id_alu_op),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_pc(id_pc),
    .exmem_reg_write(exmem_reg_write), .exmem_mem_to_reg(exmem_mem_to_reg),
    .exmem_rd(exmem_rd),
    .hold(hold), .ex_flush(ex_flush), .cnt_clr(cnt_clr),
    .idex_valid(idex_valid), .idex_reg_write(idex_reg_write),
    .idex_mem_to_reg(idex_mem_to_reg), .idex_mem_write(idex_mem_write),
    .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
    .idex_alu_op(idex_alu_op),
    .idex_rs1_data(idex_rs1_data), .idex_rs2_data(idex_rs2_data),
    .idex_imm(idex_imm), .idex_pc(idex_pc),
    .stall_if_id(stall_if_id), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic        valid, u1, u2, rw, m2r, mw;
    logic [3:0]  rs1, rs2, rd, alu;
    logic [15:0] d1, d2, imm, pc;
  } instr_t;

  typedef struct packed {
    logic        valid, rw, m2r, mw;
    logic [3:0]  rs1, rs2, rd, alu;
    logic [15:0] d1, d2, imm, pc;
  } fld_t;

  typedef struct packed {
    logic        stall;
    fld_t        f;
    logic [15:0] cnt;
  } obs_t;

  // Model state and tb-driven EX/MEM stage
  fld_t        mf;
  logic [15:0] mcnt;
  instr_t      cur;
  logic        ex_rw, ex_m2r, ex_pin;
  logic [3:0]  ex_rd;
  logic        stall_seen;
  logic        last_exp_stall;
  logic [15:0] pc_ctr;
  obs_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  assign exmem_reg_write  = ex_rw;
  assign exmem_mem_to_reg = ex_m2r;
  assign exmem_rd         = ex_rd;

  function automatic instr_t mk(input logic v, u1, u2, rw, m2r, mw,
                                input logic [3:0] rd, rs1, rs2, alu);
    instr_t i;
    i.valid = v; i.u1 = u1; i.u2 = u2; i.rw = rw; i.m2r = m2r; i.mw = mw;
    i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.alu = alu;
    i.d1  = 16'($urandom);
    i.d2  = 16'($urandom);
    i.imm = 16'($urandom);
    i.pc  = pc_ctr;
    pc_ctr = pc_ctr + 16'd2;
    return i;
  endfunction

  function automatic instr_t lw(input logic [3:0] rd, rs1);
    return mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, rd, rs1, 4'd0, 4'd0);
  endfunction

  function automatic instr_t alu3(input logic [3:0] rd, rs1, rs2, op);
    return mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, rd, rs1, rs2, op);
  endfunction

  function automatic instr_t alui(input logic [3:0] rd, rs1, rs2_field);
    return mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, rd, rs1, rs2_field, 4'd5);
  endfunction

  function automatic instr_t nop_i();
    return mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 4'd3, 4'd3, 4'd7);
  endfunction

  task automatic drive(input instr_t i);
    cur = i;
    id_valid = i.valid; id_uses_rs1 = i.u1; id_uses_rs2 = i.u2;
    id_reg_write = i.rw; id_mem_to_reg = i.m2r; id_mem_write = i.mw;
    id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd; id_alu_op = i.alu;
    id_rs1_data = i.d1; id_rs2_data = i.d2; id_imm = i.imm; id_pc = i.pc;
  endtask

  // Load-use condition straight from the hazard definition.
  function automatic logic model_lu();
    logic a, b;
    a = mf.valid && mf.rw && mf.m2r && (mf.rd != 4'd0) &&
        ((cur.u1 && cur.rs1 == mf.rd) || (cur.u2 && cur.rs2 == mf.rd));
    b = ex_rw && ex_m2r && (ex_rd != 4'd0) &&
        ((cur.u1 && cur.rs1 == ex_rd) || (cur.u2 && cur.rs2 == ex_rd));
    return cur.valid && (a || b);
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o = {stall_seen, idex_valid, idex_reg_write, idex_mem_to_reg, idex_mem_write,
         idex_rs1, idex_rs2, idex_rd, idex_alu_op,
         idex_rs1_data, idex_rs2_data, idex_imm, idex_pc, stall_cnt};
    return o;
  endfunction

  // One clock: predict, push, clock, advance tb EX/MEM, pop and compare.
  task automatic cycle(input string tag);
    obs_t nm, exp, got;
    fld_t cap;
    logic l;
    @(negedge clk);
    l = model_lu();
    cap = '{valid: 1'b1, rw: cur.rw, m2r: cur.m2r, mw: cur.mw,
            rs1: cur.rs1, rs2: cur.rs2, rd: cur.rd, alu: cur.alu,
            d1: cur.d1, d2: cur.d2, imm: cur.imm, pc: cur.pc};
    nm.stall = hold | (l & ~ex_flush);
    nm.f     = mf;
    nm.cnt   = mcnt;
    if (!hold) nm.f = (ex_flush || l || !cur.valid) ? fld_t'('0) : cap;
    if (cnt_clr) nm.cnt = 16'd0;
    else if (!hold && !ex_flush && l && mcnt != 16'hFFFF) nm.cnt = mcnt + 16'd1;
    sb.push_back(nm);
    last_exp_stall = nm.stall;
    stall_seen = stall_if_id;
    @(posedge clk);
    #1;
    if (!hold && !ex_pin) begin
      ex_rw = mf.valid & mf.rw; ex_m2r = mf.m2r; ex_rd = mf.rd;
    end
    mf = nm.f; mcnt = nm.cnt;
    exp = sb.pop_front();
    got = observe();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL sb_%s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    drive(nop_i());
    for (int k = 0; k < n; k++) cycle("idle");
  endtask

  // Present an instruction until ID/EX accepts it; returns the stall cycles seen.
  task automatic issue(input instr_t i, output int stalls);
    drive(i);
    stalls = 0;
    for (int k = 0; k < 8; k++) begin
      cycle("issue");
      if (!last_exp_stall) return;
      stalls++;
    end
    n_tests++; n_fail++;
    $display("FAIL issue_timeout pc=%h stalls=%0d limit=8", i.pc, stalls);
  endtask

  task automatic clear_cnt();
    idle(3);
    cnt_clr = 1'b1; cycle("clr"); cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({idex_valid, idex_rd, idex_rs1, idex_rs2, idex_pc, idex_imm, stall_cnt, stall_if_id} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got valid=%b rd=%h pc=%h cnt=%h stall=%b want all 0",
               idex_valid, idex_rd, idex_pc, stall_cnt, stall_if_id);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    // First edge after release behaves normally.
    begin int s; issue(alu3(4'd2, 4'd1, 4'd1, 4'd1), s); end
    n_tests++;
    if (idex_valid !== 1'b1 || idex_rd !== 4'd2) begin
      n_fail++;
      $display("FAIL reset_first_capture got valid=%b rd=%h want 1/2", idex_valid, idex_rd);
    end
  endtask

  task automatic test_back_to_back();
    int s;
    clear_cnt();
    issue(lw(4'd3, 4'd1), s);
    issue(alu3(4'd4, 4'd3, 4'd5, 4'd1), s);
    n_tests++;
    if (s !== 2) begin n_fail++; $display("FAIL b2b_stalls got=%0d want=2", s); end
    n_tests++;
    if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL b2b_cnt got=%0d want=2", stall_cnt); end
    n_tests++;
    if (idex_rd !== 4'd4 || idex_rs1 !== 4'd3 || idex_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_capture got rd=%h rs1=%h valid=%b want 4/3/1", idex_rd, idex_rs1, idex_valid);
    end
  endtask

  task automatic test_load_indep_use();
    int s1, s2;
    clear_cnt();
    issue(lw(4'd3, 4'd2), s1);
    issue(alu3(4'd6, 4'd1, 4'd2, 4'd1), s1);
    issue(alu3(4'd7, 4'd3, 4'd1, 4'd2), s2);
    n_tests++;
    if (s1 !== 0 || s2 !== 1) begin n_fail++; $display("FAIL liu_stalls got=%0d/%0d want=0/1", s1, s2); end
    n_tests++;
    if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL liu_cnt got=%0d want=1", stall_cnt); end
  endtask

  task automatic test_r0_and_unused();
    int s;
    clear_cnt();
    issue(lw(4'd0, 4'd1), s);
    issue(alu3(4'd4, 4'd0, 4'd5, 4'd1), s);
    n_tests++;
    if (s !== 0 || stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL r0_nostall got stalls=%0d cnt=%0d want 0/0", s, stall_cnt);
    end
    idle(2);
    issue(lw(4'd3, 4'd1), s);
    issue(alui(4'd8, 4'd1, 4'd3), s);
    n_tests++;
    if (s !== 0 || stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL unused_src got stalls=%0d cnt=%0d want 0/0", s, stall_cnt);
    end
  endtask

  task automatic test_flush();
    int s;
    clear_cnt();
    issue(lw(4'd3, 4'd1), s);
    drive(alu3(4'd4, 4'd3, 4'd5, 4'd1));
    ex_flush = 1'b1;
    cycle("flush");
    ex_flush = 1'b0;
    n_tests++;
    if (stall_seen !== 1'b0) begin n_fail++; $display("FAIL flush_stall got=%b want=0", stall_seen); end
    n_tests++;
    if (idex_valid !== 1'b0 || idex_rd !== 4'd0 || idex_pc !== 16'd0 || stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL flush_bubble got valid=%b rd=%h pc=%h cnt=%0d want 0/0/0/0",
                         idex_valid, idex_rd, idex_pc, stall_cnt);
    end
    idle(3);
  endtask

  task automatic test_hold();
    int s;
    clear_cnt();
    issue(lw(4'd3, 4'd1), s);
    drive(alu3(4'd4, 4'd3, 4'd5, 4'd1));
    hold = 1'b1; ex_flush = 1'b1;
    cycle("hold");
    cycle("hold");
    hold = 1'b0; ex_flush = 1'b0;
    n_tests++;
    if (stall_seen !== 1'b1 || idex_valid !== 1'b1 || idex_rd !== 4'd3 || idex_mem_to_reg !== 1'b1 ||
        stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL hold_keep got stall=%b valid=%b rd=%h m2r=%b cnt=%0d want 1/1/3/1/0",
                         stall_seen, idex_valid, idex_rd, idex_mem_to_reg, stall_cnt);
    end
    issue(alu3(4'd4, 4'd3, 4'd5, 4'd1), s);
    n_tests++;
    if (s !== 2 || stall_cnt !== 16'd2) begin
      n_fail++; $display("FAIL hold_release got stalls=%0d cnt=%0d want 2/2", s, stall_cnt);
    end
  endtask

  task automatic test_saturation_and_reset();
    clear_cnt();
    // Keep a load to r3 parked in EX/MEM so every edge is a load-use bubble.
    ex_pin = 1'b1; ex_rw = 1'b1; ex_m2r = 1'b1; ex_rd = 4'd3;
    drive(alu3(4'd4, 4'd3, 4'd5, 4'd1));
    for (int k = 0; k < 65534; k++) cycle("sat");
    n_tests++;
    if (stall_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_preload got=%h want=fffe", stall_cnt); end
    cycle("sat"); cycle("sat");
    n_tests++;
    if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach got=%h want=ffff", stall_cnt); end
    cycle("sat");
    n_tests++;
    if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got=%h want=ffff", stall_cnt); end
    cnt_clr = 1'b1; cycle("clr_prio"); cnt_clr = 1'b0;
    n_tests++;
    if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_priority got=%h want=0", stall_cnt); end
    // Put real state in the register, then reset in the middle of a stall.
    ex_pin = 1'b0; ex_rw = 1'b0; ex_m2r = 1'b0; ex_rd = 4'd0;
    begin int s; issue(lw(4'd3, 4'd1), s); end
    drive(alu3(4'd4, 4'd3, 4'd5, 4'd1));
    cycle("mid");
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({idex_valid, idex_reg_write, idex_mem_to_reg, idex_mem_write, idex_rs1, idex_rs2, idex_rd,
         idex_alu_op, idex_rs1_data, idex_rs2_data, idex_imm, idex_pc, stall_cnt} !== '0) begin
      n_fail++; $display("FAIL async_reset got valid=%b rd=%h pc=%h cnt=%h want all 0",
                         idex_valid, idex_rd, idex_pc, stall_cnt);
    end
    mf = '0; mcnt = 16'd0; ex_rw = 1'b0; ex_m2r = 1'b0; ex_rd = 4'd0;
    drive(nop_i());
    #1 rst_n = 1'b1;
    begin int s; issue(alu3(4'd9, 4'd3, 4'd3, 4'd1), s);
      n_tests++;
      if (s !== 0 || idex_rd !== 4'd9) begin
        n_fail++; $display("FAIL post_reset got stalls=%0d rd=%h want 0/9", s, idex_rd);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    hold = 1'b0; ex_flush = 1'b0; cnt_clr = 1'b0;
    ex_pin = 1'b0; ex_rw = 1'b0; ex_m2r = 1'b0; ex_rd = 4'd0;
    pc_ctr = 16'h0100;
    mf = '0; mcnt = 16'd0; stall_seen = 1'b0; last_exp_stall = 1'b0;
    id_valid = 1'b0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    id_reg_write = 1'b0; id_mem_to_reg = 1'b0; id_mem_write = 1'b0;
    id_rs1 = 4'd0; id_rs2 = 4'd0; id_rd = 4'd0; id_alu_op = 4'd0;
    id_rs1_data = 16'd0; id_rs2_data = 16'd0; id_imm = 16'd0; id_pc = 16'd0;
    cur = '0;
    #12;
    test_reset();
    test_back_to_back();
    test_load_indep_use();
    test_r0_and_unused();
    test_flush();
    test_hold();
    test_saturation_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
